// File: rtl/card_dealer_if.sv
// Register-file load bus between the card dealer and its consumers.
// The dealer drives the write port and status strobes; the game logic drives start.
interface card_dealer_if;
  logic        start;
  logic [18:0] write_data_1;
  logic        read_all_cards;
  logic        busy;
  logic        done;

  modport master (
    input  start,
    output write_data_1,
    output read_all_cards,
    output busy,
    output done
  );

  modport slave (
    output start,
    input  write_data_1,
    input  read_all_cards,
    input  busy,
    input  done
  );
endinterface

// File: rtl/card_dealer.sv
// Deals a shuffled deck of symbol pairs into the card register file, one card per cycle,
// then strobes read_all_cards/done. Shuffle randomness comes from a free-running LFSR.
module card_dealer #(
  parameter int          NUM_CARDS = 12,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst,
  card_dealer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    SHUFFLE = 3'd2,
    WRITE   = 3'd3,
    FINISH  = 3'd4
  } state_e;

  localparam logic [3:0] LAST_IDX = 4'(NUM_CARDS - 1);

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [2:0]  deck_q [NUM_CARDS];
  logic [2:0]  deck_d [NUM_CARDS];
  logic [3:0]  i_q, i_d;
  logic [3:0]  k_q, k_d;
  logic [3:0]  j;

  logic [18:0] write_data_q, write_data_d;
  logic        read_all_q, read_all_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign j      = lfsr_q[3:0];

  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case can infer a latch.
    state_d = state_q;
    i_d     = i_q;
    k_d     = k_q;
    deck_d  = deck_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = INIT;
      end
      INIT: begin
        for (int n = 0; n < NUM_CARDS; n++) deck_d[n] = 3'(n >> 1);
        i_d     = LAST_IDX;
        state_d = SHUFFLE;
      end
      SHUFFLE: begin
        // Rejection sampling: an out-of-range j just waits for the next LFSR value.
        if (i_q == 4'd0) begin
          k_d     = 4'd0;
          state_d = WRITE;
        end else if (j <= i_q) begin
          deck_d[i_q] = deck_q[j];
          deck_d[j]   = deck_q[i_q];
          i_d         = i_q - 4'd1;
        end
      end
      WRITE: begin
        if (k_q == LAST_IDX) state_d = FINISH;
        else                 k_d     = k_q + 4'd1;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered, so they are computed for the state being entered.
    write_data_d = '0;
    read_all_d   = 1'b0;
    done_d       = 1'b0;
    busy_d       = (state_d == INIT) || (state_d == SHUFFLE) || (state_d == WRITE);
    if (state_d == WRITE) begin
      write_data_d = {9'b0, deck_d[k_d], 2'b00, k_d + 4'd1, 1'b1};
    end
    if (state_d == FINISH) begin
      read_all_d = 1'b1;
      done_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q      <= IDLE;
      lfsr_q       <= SEED;
      i_q          <= '0;
      k_q          <= '0;
      write_data_q <= '0;
      read_all_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      // NOTE: the deck is a small flop array rather than a RAM, so it can be cleared here.
      for (int n = 0; n < NUM_CARDS; n++) deck_q[n] <= '0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      i_q          <= i_d;
      k_q          <= k_d;
      write_data_q <= write_data_d;
      read_all_q   <= read_all_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      deck_q       <= deck_d;
    end
  end

  assign bus.write_data_1   = write_data_q;
  assign bus.read_all_cards = read_all_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: a reference LFSR/shuffle model predicts every deal,
// and each output cycle is compared against it with immediate assertions.
module tb_card_dealer;
  localparam int          N    = 12;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  card_dealer_if bus ();

  card_dealer #(.NUM_CARDS(N), .SEED(SEED)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] m_lfsr;
  logic [2:0]  exp_deck   [N];
  logic [2:0]  obs_deck   [N];
  logic [2:0]  first_deck [N];
  int          exp_s;
  int          addr_cnt [16];
  int          sym_cnt  [8];

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  // Reference LFSR runs in lockstep with the DUT's free-running one.
  always @(posedge clk) m_lfsr <= rst ? SEED : lfsr_next(m_lfsr);

  function automatic logic [31:0] outs();
    return {10'b0, bus.read_all_cards, bus.done, bus.busy, bus.write_data_1};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fisher-Yates with rejection, starting from the LFSR value seen in the first SHUFFLE cycle.
  task automatic predict(input logic [15:0] l0);
    logic [15:0] l;
    logic [3:0]  j;
    logic [2:0]  t;
    int          i;
    l = l0;
    i = N - 1;
    for (int k = 0; k < N; k++) exp_deck[k] = 3'(k >> 1);
    exp_s = 0;
    while (exp_s < 1000) begin
      exp_s++;
      if (i == 0) break;
      j = l[3:0];
      if (int'(j) <= i) begin
        t           = exp_deck[i];
        exp_deck[i] = exp_deck[j];
        exp_deck[j] = t;
        i--;
      end
      l = lfsr_next(l);
    end
  endtask

  task automatic check_idle(input string tag, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      tick();
      check($sformatf("%s idle%0d", tag, c), outs(), 32'h0);
    end
  endtask

  // Starts a deal from IDLE and checks every cycle through FINISH.
  // pulse_sh/pulse_wr inject extra start pulses; rst_wr asserts rst during that write number.
  task automatic run_deal(input string tag, input int pulse_sh, input int pulse_wr,
                          input int rst_wr, input bit hold);
    int n;
    bus.start = 1'b1;
    tick();
    bus.start = hold;
    check({tag, " busy rise"}, outs(), {10'b0, 3'b001, 19'b0});
    predict(lfsr_next(m_lfsr));
    addr_cnt = '{default: 0};
    sym_cnt  = '{default: 0};
    for (int off = 1; off <= exp_s + 13; off++) begin
      bus.start = hold || (off == pulse_sh) || (pulse_wr >= 0 && off == exp_s + 2 + pulse_wr);
      tick();
      n = off - exp_s - 1;
      if (off <= exp_s) begin
        check($sformatf("%s shuffle%0d", tag, off), outs(), {10'b0, 3'b001, 19'b0});
      end else if (n < N) begin
        check($sformatf("%s write%0d", tag, n), outs(),
              {10'b0, 3'b001, 9'b0, exp_deck[n], 2'b00, 4'(n + 1), 1'b1});
        obs_deck[n] = bus.write_data_1[9:7];
        if (bus.write_data_1[0]) begin
          addr_cnt[bus.write_data_1[4:1]]++;
          sym_cnt[bus.write_data_1[9:7]]++;
        end
        if (rst_wr == n + 1) begin
          bus.start = 1'b0;
          rst       = 1'b1;
          tick();
          rst = 1'b0;
          check({tag, " after rst"}, outs(), 32'h0);
          return;
        end
      end else begin
        check({tag, " finish"}, outs(), {10'b0, 3'b110, 19'b0});
      end
    end
    for (int a = 1; a <= N; a++) check($sformatf("%s addr%0d once", tag, a), addr_cnt[a], 1);
    for (int s = 0; s < N / 2; s++) check($sformatf("%s sym%0d twice", tag, s), sym_cnt[s], 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int diff;
    rst       = 1'b1;
    bus.start = 1'b0;
    tick();
    tick();
    bus.start = 1'b1;
    tick();
    check("rst beats start", outs(), 32'h0);
    bus.start = 1'b0;
    rst       = 1'b0;
    check("reset outputs", outs(), 32'h0);

    // Basic deal, started five cycles after reset.
    repeat (5) tick();
    run_deal("deal1", 0, -1, 0, 1'b0);
    check_idle("deal1 post", 3);

    // Start pulses during SHUFFLE and WRITE must be ignored.
    run_deal("ignore", 3, 4, 0, 1'b0);
    check_idle("ignore post", 4);

    // Reset during the 4th write aborts the deal without a done pulse.
    run_deal("abort", 0, -1, 4, 1'b0);
    check_idle("abort post", 5);
    run_deal("redeal", 0, -1, 0, 1'b0);
    check_idle("redeal post", 2);

    // Start timing relative to reset changes the deal.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    run_deal("delay1", 0, -1, 0, 1'b0);
    for (int k = 0; k < N; k++) first_deck[k] = obs_deck[k];
    check_idle("delay1 post", 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (7) tick();
    run_deal("delay7", 0, -1, 0, 1'b0);
    diff = 0;
    for (int k = 0; k < N; k++) if (first_deck[k] !== obs_deck[k]) diff++;
    check("orders differ", (diff != 0) ? 32'd1 : 32'd0, 32'd1);
    check_idle("delay7 post", 1);

    // Held start re-deals back to back with one zero-bus IDLE cycle between deals.
    for (int d = 0; d < 3; d++) begin
      run_deal($sformatf("held%0d", d), 0, -1, 0, 1'b1);
      tick();
      check($sformatf("held%0d gap", d), outs(), 32'h0);
    end
    bus.start = 1'b0;
    check_idle("final", 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
